uart_prog_loader: RTL and testbench

- Receives a program image over the board serial line (UART_RXD) and writes it, one 32-bit word at a time, into the instruction memory that the single-cycle core reads.
- Lets a new program be loaded without resynthesis. The core is held while busy is high.
- Contains a UART receiver (8N1, LSB first) and a framing state machine (header, count, data, checksum) that generates the memory write strobes.

---
 rtl/uart_prog_loader.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// ---------------------------------------------------------------------------
// uart_prog_loader
//
// Receives a program image over the board serial line and writes it, one
// 32-bit word per strobe, into the instruction memory of the single-cycle
// core. A session has four parts: a header byte, a word count N, 4*N data
// bytes (little-endian per word) and one checksum byte (XOR of all data
// bytes). The core is expected to be held in reset while busy is high.
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active low
//   rxd        serial input (8N1, LSB first, idle high), asynchronous to clk
//   mem_we     one-cycle word write strobe
//   mem_addr   word index of the write (holds between strobes)
//   mem_wdata  assembled 32-bit word (holds between strobes)
//   busy       a session is in progress
//   done       last session finished with a matching checksum
//   chk_err    last session finished with a checksum mismatch
//   frame_err  a stop bit was 0 during the last session
//   word_count words written in the current or last session
// ---------------------------------------------------------------------------
module uart_prog_loader #(
    parameter int         CLK_FREQ     = 50000000,
    parameter int         BAUD         = 115200,
    parameter int         CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int         ADDR_W       = 8,
    parameter logic [7:0] HDR_BYTE     = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              chk_err,
    output logic              frame_err,
    output logic [ADDR_W:0]   word_count
);

    localparam int                 CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam int                 HALF_BIT  = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0]   BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]   HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [ADDR_W:0]    WC_ONE    = (ADDR_W + 1)'(1);
    // A count byte of zero stands for a full memory image.
    localparam logic [ADDR_W:0]    WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};

    // -----------------------------------------------------------------------
    // Input synchronizer
    // -----------------------------------------------------------------------
    logic rxd_meta;
    logic rxd_sync;

    // Two-flop synchronizer; both flops come out of reset high so the idle
    // line is not mistaken for a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
        end
    end

    // -----------------------------------------------------------------------
    // UART receiver
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    rx_state_t        rx_state;
    rx_state_t        rx_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_shift;
    logic             stop_wait;
    logic             byte_valid;
    logic             byte_err;

    // Receiver state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state <= R_IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    // Receiver next state. A start bit must still be low at its midpoint,
    // otherwise it was a glitch. After a bad stop bit the receiver parks in
    // R_STOP until the line is high again so the low stop bit is not taken
    // as the next start bit.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            R_IDLE: begin
                if (!rxd_sync) begin
                    rx_next = R_START;
                end
            end
            R_START: begin
                if (bit_cnt == HALF_LAST) begin
                    rx_next = rxd_sync ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (bit_cnt == BIT_LAST && bit_idx == 3'd7) begin
                    rx_next = R_STOP;
                end
            end
            R_STOP: begin
                if (stop_wait) begin
                    if (rxd_sync) begin
                        rx_next = R_IDLE;
                    end
                end else if (bit_cnt == BIT_LAST && rxd_sync) begin
                    rx_next = R_IDLE;
                end
            end
            default: rx_next = R_IDLE;
        endcase
    end

    // Receiver outputs: one-cycle pulses at the stop-bit sample point.
    always_comb begin
        byte_valid = 1'b0;
        byte_err   = 1'b0;
        if (rx_state == R_STOP && !stop_wait && bit_cnt == BIT_LAST) begin
            byte_valid = rxd_sync;
            byte_err   = !rxd_sync;
        end
    end

    // Receiver datapath: bit timing counter, bit index and shift register.
    // Data enters at the top so the first (least significant) bit ends up
    // in bit 0 after eight shifts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt   <= '0;
            bit_idx   <= '0;
            rx_shift  <= '0;
            stop_wait <= 1'b0;
        end else begin
            case (rx_state)
                R_IDLE: begin
                    bit_cnt   <= '0;
                    bit_idx   <= '0;
                    stop_wait <= 1'b0;
                end
                R_START: begin
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt  <= '0;
                        rx_shift <= {rxd_sync, rx_shift[7:1]};
                        bit_idx  <= bit_idx + 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (!stop_wait) begin
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt   <= '0;
                            stop_wait <= !rxd_sync;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Loader framing state machine
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        L_IDLE,
        L_COUNT,
        L_DATA,
        L_CHK
    } ld_state_t;

    ld_state_t         ld_state;
    ld_state_t         ld_next;
    logic [ADDR_W:0]   words_target;
    logic [ADDR_W-1:0] wr_index;
    logic [1:0]        byte_idx;
    logic [7:0]        chk_acc;
    logic [23:0]       word_buf;

    logic start_session;
    logic take_count;
    logic take_data;
    logic word_full;
    logic last_word;
    logic take_chk;
    logic abort;

    // Loader state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_state <= L_IDLE;
        end else begin
            ld_state <= ld_next;
        end
    end

    // Loader next state. A framing error anywhere inside a session ends it.
    always_comb begin
        ld_next = ld_state;
        if (abort) begin
            ld_next = L_IDLE;
        end else begin
            case (ld_state)
                L_IDLE:  if (start_session) ld_next = L_COUNT;
                L_COUNT: if (take_count)    ld_next = L_DATA;
                L_DATA:  if (last_word)     ld_next = L_CHK;
                L_CHK:   if (take_chk)      ld_next = L_IDLE;
                default: ld_next = L_IDLE;
            endcase
        end
    end

    // Loader control decode: what the current byte means in this state.
    // Inside L_DATA every byte is payload, including one equal to HDR_BYTE.
    always_comb begin
        start_session = (ld_state == L_IDLE) && byte_valid && (rx_shift == HDR_BYTE);
        take_count    = (ld_state == L_COUNT) && byte_valid;
        take_data     = (ld_state == L_DATA) && byte_valid;
        word_full     = take_data && (byte_idx == 2'd3);
        last_word     = word_full && ((word_count + WC_ONE) == words_target);
        take_chk      = (ld_state == L_CHK) && byte_valid;
        abort         = (ld_state != L_IDLE) && byte_err;
    end

    // Loader datapath and registered outputs. The fourth byte of a word goes
    // straight into mem_wdata, so only three bytes are buffered. mem_addr
    // and mem_wdata change only together with a write strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            chk_err      <= 1'b0;
            frame_err    <= 1'b0;
            word_count   <= '0;
            words_target <= '0;
            wr_index     <= '0;
            byte_idx     <= '0;
            chk_acc      <= '0;
            word_buf     <= '0;
        end else begin
            mem_we <= 1'b0;

            if (start_session) begin
                busy       <= 1'b1;
                done       <= 1'b0;
                chk_err    <= 1'b0;
                frame_err  <= 1'b0;
                word_count <= '0;
                wr_index   <= '0;
                byte_idx   <= '0;
                chk_acc    <= '0;
            end

            if (take_count) begin
                words_target <= (rx_shift == 8'd0) ? WORDS_MAX : (ADDR_W + 1)'(rx_shift);
            end

            if (take_data) begin
                chk_acc  <= chk_acc ^ rx_shift;
                byte_idx <= byte_idx + 1'b1;
                case (byte_idx)
                    2'd0:    word_buf[7:0]   <= rx_shift;
                    2'd1:    word_buf[15:8]  <= rx_shift;
                    2'd2:    word_buf[23:16] <= rx_shift;
                    default: begin
                        mem_we     <= 1'b1;
                        mem_wdata  <= {rx_shift, word_buf};
                        mem_addr   <= wr_index;
                        wr_index   <= wr_index + 1'b1;
                        word_count <= word_count + WC_ONE;
                    end
                endcase
            end

            if (take_chk) begin
                if (rx_shift == chk_acc) begin
                    done <= 1'b1;
                end else begin
                    chk_err <= 1'b1;
                end
                busy <= 1'b0;
            end

            if (abort) begin
                frame_err <= 1'b1;
                busy      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_prog_loader
//
// Self-checking bench for uart_prog_loader. Drives serial frames on rxd,
// captures every write strobe into a queue, and compares it with the list
// of writes the session should produce (word i of a session lands at index
// i), plus the status outputs after each session.
// ---------------------------------------------------------------------------
module tb_uart_prog_loader;

    localparam int CPB    = 8;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              rxd;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              chk_err;
    logic              frame_err;
    logic [ADDR_W:0]   word_count;

    int check_count = 0;
    int fail_count  = 0;

    logic [ADDR_W+31:0] obs_q[$];
    logic [ADDR_W+31:0] exp_q[$];
    logic [31:0]        session_words[$];

    always #5 clk = ~clk;

    uart_prog_loader #(
        .CLK_FREQ    (50000000),
        .BAUD        (115200),
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (ADDR_W),
        .HDR_BYTE    (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .chk_err   (chk_err),
        .frame_err (frame_err),
        .word_count(word_count)
    );

    // Record every write strobe, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst && mem_we) begin
            obs_q.push_back({mem_addr, mem_wdata});
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        check_count++;
        if (got !== want) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // One 8N1 frame, LSB first, with a selectable stop bit value.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic idleLine(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic compareWrites(input string tag);
        checkOutput({tag, "_wr_n"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checkOutput($sformatf("%s_wr%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic checkFlags(input string tag, input logic b, input logic d, input logic c,
                              input logic f, input logic [ADDR_W:0] wc);
        checkOutput({tag, "_busy"}, 64'(busy), 64'(b));
        checkOutput({tag, "_done"}, 64'(done), 64'(d));
        checkOutput({tag, "_chk_err"}, 64'(chk_err), 64'(c));
        checkOutput({tag, "_frame_err"}, 64'(frame_err), 64'(f));
        checkOutput({tag, "_word_count"}, 64'(word_count), 64'(wc));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        checkOutput({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        checkOutput({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        checkFlags(tag, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // Full session from session_words. ferr_at >= 0 sends that data byte
    // with a bad stop bit and ends the session there; chk_flip != 0 corrupts
    // the checksum byte.
    task automatic runSession(input string tag, input logic [7:0] n_field, input int ferr_at,
                              input logic [7:0] chk_flip);
        logic [7:0]  chk;
        logic [7:0]  b;
        logic [31:0] w;
        int          nwords;
        nwords = (n_field == 8'd0) ? 256 : int'(n_field);
        chk = 8'd0;
        obs_q.delete();
        exp_q.delete();
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(n_field, 1'b1);
        for (int k = 0; k < nwords * 4; k++) begin
            w = session_words[k / 4];
            b = w[8 * (k % 4) +: 8];
            if (k == ferr_at) begin
                idleLine(3);
                checkOutput({tag, "_mid_busy"}, 64'(busy), 64'd1);
                checkOutput({tag, "_mid_word_count"}, 64'(word_count), 64'(k / 4));
                applyStimulus(b, 1'b0);
                break;
            end
            applyStimulus(b, 1'b1);
            chk = chk ^ b;
            if (k % 4 == 3) begin
                exp_q.push_back({ADDR_W'(k / 4), w});
            end
        end
        if (ferr_at < 0) begin
            applyStimulus(chk ^ chk_flip, 1'b1);
        end
        idleLine(20);
        compareWrites(tag);
        if (ferr_at >= 0) begin
            checkFlags(tag, 1'b0, 1'b0, 1'b0, 1'b1, (ADDR_W + 1)'(ferr_at / 4));
        end else begin
            checkFlags(tag, 1'b0, chk_flip == 8'd0, chk_flip != 8'd0, 1'b0, (ADDR_W + 1)'(nwords));
        end
    endtask

    initial begin
        int          n;
        int          mode;
        logic [31:0] w;
        logic [7:0]  b;

        rst = 1'b0;
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        checkResetState("reset");
        rst = 1'b1;
        idleLine(10);

        session_words = '{32'h0000_0013};
        runSession("one_word", 8'd1, -1, 8'd0);

        session_words = '{32'h0050_0093, 32'h00A0_0113};
        runSession("two_words", 8'd2, -1, 8'd0);
        runSession("bad_chk", 8'd2, -1, 8'h40);

        session_words = '{32'h1122_3344, 32'h5566_7788};
        runSession("ferr_byte3", 8'd2, 2, 8'd0);

        // Idle-line disturbances: a short glitch, non-header bytes and a
        // bad stop bit must all leave the status outputs untouched.
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        idleLine(40);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        applyStimulus(8'h3C, 1'b0);
        idleLine(20);
        compareWrites("idle_noise");
        checkFlags("idle_noise", 1'b0, 1'b0, 1'b0, 1'b1, '0);

        session_words = '{32'hA5A5_00A5, 32'h0A5A_A5A5};
        runSession("hdr_as_data", 8'd2, -1, 8'd0);

        // Count byte 0 means 256 words: after five words the session must
        // still be running; it is then ended with a framing error.
        session_words = {};
        for (int i = 0; i < 6; i++) session_words.push_back($urandom);
        runSession("count_zero", 8'd0, 20, 8'd0);

        // Reset partway through word 2 of a four-word session.
        session_words = '{32'h0102_0304, 32'h1112_1314, 32'h2122_2324, 32'h3132_3334};
        obs_q.delete();
        exp_q.delete();
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(8'h04, 1'b1);
        for (int k = 0; k < 6; k++) begin
            w = session_words[k / 4];
            b = w[8 * (k % 4) +: 8];
            applyStimulus(b, 1'b1);
        end
        exp_q.push_back({ADDR_W'(0), session_words[0]});
        idleLine(3);
        rst = 1'b0;
        #2;
        checkResetState("rst_mid");
        repeat (4) @(negedge clk);
        rst = 1'b1;
        for (int k = 6; k < 16; k++) begin
            w = session_words[k / 4];
            b = w[8 * (k % 4) +: 8];
            applyStimulus(b, 1'b1);
        end
        applyStimulus(8'h3E, 1'b1);
        idleLine(20);
        compareWrites("rst_mid");
        checkFlags("rst_after", 1'b0, 1'b0, 1'b0, 1'b0, '0);

        session_words = '{32'hDEAD_BEEF};
        runSession("post_rst", 8'd1, -1, 8'd0);

        // Randomized sessions: clean, corrupted checksum, or framing error.
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 6);
            mode = $urandom_range(0, 2);
            session_words = {};
            for (int i = 0; i < n; i++) session_words.push_back($urandom);
            if (mode == 0) begin
                runSession($sformatf("rand%0d_ok", r), 8'(n), -1, 8'd0);
            end else if (mode == 1) begin
                runSession($sformatf("rand%0d_chk", r), 8'(n), -1, 8'($urandom_range(1, 255)));
            end else begin
                runSession($sformatf("rand%0d_ferr", r), 8'(n), $urandom_range(0, 4 * n - 1), 8'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
